arcade_input_map: RTL and testbench
===================================

# arcade_input_map

Parametrised keyboard/joystick-to-arcade-control mapper for the emu top level, replacing hand-written per-core PS/2 decode and rotation wiring. Decodes MiSTer `ps2_key` events into held key state, ORs with up to four joysticks, applies one of four screen rotations and optional opposing-direction cleanup, and generates fixed-length coin pulses. Outputs are active-high per-player control bytes; the core wrapper inverts them as the board requires.

## Interface
- `NUM_PLAYERS`, 2: players mapped, 1–4; keyboard feeds players 1–2 only.
- `COIN_TICKS`, 4: `coin_ce` ticks a coin pulse lasts, 1–15.
- `SOCD_CLEAN`, 1: when 1, simultaneous up+down or left+right output as neither.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ps2_key` in 11: [10] toggle per event, [9] pressed, [8] extended, [7:0] scan code.
- `joystick` in 16*NUM_PLAYERS: player p at [16p+15:16p]; bits [0] right [1] left [2] down [3] up [4] fire1 [5] fire2 [6] start [7] coin.
- `rotate` in 2: 0 none, 1 horizontal (90°), 2 180°, 3 270°.
- `coin_ce` in 1: one-cycle tick for coin timing (typically per frame).
- `p_ctl` out 8*NUM_PLAYERS: player p at [8p+7:8p]; [0] up [1] down [2] left [3] right [4] fire1 [5] fire2 [6] start [7] coin.

## Operation
- Event detect: `ps2_key[10]` differing from registered copy = one event; update matching key-state bit to `ps2_key[9]`. Unmatched codes ignored.
- Player 1 keys: up 75, down 72, left 6B, right 74 (extended bit ignored); fire1 14 or 29; fire2 11; start 16; coin 2E. Player 2: up 2D, down 2B, left 23, right 34; fire1 1C; fire2 1B; start 1E; coin 36.
- Raw per player = key state | registered joystick bits (bit reorder into `p_ctl` order).
- Rotation on directions only: mode 1 up←left, down←right, left←down, right←up; mode 2 up↔down, left↔right; mode 3 up←right, down←left, left←up, right←down.
- SOCD applied after rotation.
- Coin, per player, via FSM IDLE→PULSE→WAIT_REL: IDLE and raw coin rising edge → PULSE, counter=COIN_TICKS; in PULSE, each `coin_ce` decrements, reaching 0 → WAIT_REL; WAIT_REL → IDLE when raw coin low. `p_ctl` coin bit = (state==PULSE). Retrigger during PULSE/WAIT_REL ignored.
- Unused players' slices: none exist; widths scale with NUM_PLAYERS.

## Timing
- Reset: key state 0, joystick register 0, toggle copy loaded from `ps2_key[10]` (no spurious event), coin FSMs IDLE, counters 0, `p_ctl` all 0.
- Latency: ps2 event or joystick change at edge N visible on `p_ctl` after edge N+2 (input/state register, output register).
- Coin pulse: output high from edge N+2 after edge-detected press until the edge after the COIN_TICKS-th `coin_ce` seen in PULSE; `coin_ce` in the entry cycle not counted.
- `rotate` change takes effect on next output register update; no state kept.
- Reset mid-pulse: coin drops next cycle, held key must be released and re-pressed.
- Simultaneous key event and joystick change in one cycle: both applied.

## Structure
- `arcade_input_pkg`: `p_ctl` bit indices, joystick bit indices, rotation enum, scan-code constants, coin FSM state enum.
- Sub-module `arcade_coin_pulse` (FSM + 4-bit counter), instantiated per player via generate.

## Test plan
- Reset with `ps2_key[10]`=1 → no event, `p_ctl`=0 for 2 players.
- Event toggle, pressed=1, code 75, ext=1, rotate=0 → `p_ctl[0]`=1 two edges later; release event → 0.
- Joystick0=0x0008 (up), rotate=1 → player1 right (bit 3) set; rotate=3 → left (bit 2) set; rotate=2 → down set.
- Key 75 and joystick down both held, SOCD_CLEAN=1 → bits 0,1 both 0; SOCD_CLEAN=0 → both 1.
- COIN_TICKS=4, hold key 2E for 10 `coin_ce` → coin high exactly 4 ticks, no retrigger; release and re-press → second pulse.
- Reset during coin PULSE → coin 0 next cycle; NUM_PLAYERS=4 joystick3 fire2 → `p_ctl[29]`=1.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared constants, enums and decode helpers for the arcade input mapper.
package arcade_input_pkg;

  // p_ctl bit positions within a player byte
  localparam int CTL_UP    = 0;
  localparam int CTL_DOWN  = 1;
  localparam int CTL_LEFT  = 2;
  localparam int CTL_RIGHT = 3;
  localparam int CTL_FIRE1 = 4;
  localparam int CTL_FIRE2 = 5;
  localparam int CTL_START = 6;
  localparam int CTL_COIN  = 7;

  // joystick bit positions within a player word
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE1 = 4;
  localparam int JOY_FIRE2 = 5;
  localparam int JOY_START = 6;
  localparam int JOY_COIN  = 7;

  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_90   = 2'd1,
    ROT_180  = 2'd2,
    ROT_270  = 2'd3
  } rot_e;

  typedef enum logic [1:0] {
    COIN_IDLE     = 2'd0,
    COIN_PULSE    = 2'd1,
    COIN_WAIT_REL = 2'd2
  } coin_st_e;

  // PS/2 set-2 scan codes (extended prefix is ignored for all of them)
  localparam logic [7:0] SC_P1_UP     = 8'h75;
  localparam logic [7:0] SC_P1_DOWN   = 8'h72;
  localparam logic [7:0] SC_P1_LEFT   = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT  = 8'h74;
  localparam logic [7:0] SC_P1_FIRE1A = 8'h14;
  localparam logic [7:0] SC_P1_FIRE1B = 8'h29;
  localparam logic [7:0] SC_P1_FIRE2  = 8'h11;
  localparam logic [7:0] SC_P1_START  = 8'h16;
  localparam logic [7:0] SC_P1_COIN   = 8'h2E;
  localparam logic [7:0] SC_P2_UP     = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT   = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
  localparam logic [7:0] SC_P2_FIRE1  = 8'h1C;
  localparam logic [7:0] SC_P2_FIRE2  = 8'h1B;
  localparam logic [7:0] SC_P2_START  = 8'h1E;
  localparam logic [7:0] SC_P2_COIN   = 8'h36;

  // One held-state bit per physical key; the two P1 fire keys stay separate
  // so releasing one does not drop fire while the other is still held.
  localparam int K1_UP     = 0;
  localparam int K1_DOWN   = 1;
  localparam int K1_LEFT   = 2;
  localparam int K1_RIGHT  = 3;
  localparam int K1_FIRE1A = 4;
  localparam int K1_FIRE1B = 5;
  localparam int K1_FIRE2  = 6;
  localparam int K1_START  = 7;
  localparam int K1_COIN   = 8;
  localparam int K2_UP     = 9;
  localparam int K2_DOWN   = 10;
  localparam int K2_LEFT   = 11;
  localparam int K2_RIGHT  = 12;
  localparam int K2_FIRE1  = 13;
  localparam int K2_FIRE2  = 14;
  localparam int K2_START  = 15;
  localparam int K2_COIN   = 16;
  localparam int NUM_KEYS  = 17;

  // One-hot key-state mask for a scan code; zero for unmapped codes.
  function automatic logic [NUM_KEYS-1:0] key_match(input logic [7:0] sc);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (sc)
      SC_P1_UP:     m[K1_UP]     = 1'b1;
      SC_P1_DOWN:   m[K1_DOWN]   = 1'b1;
      SC_P1_LEFT:   m[K1_LEFT]   = 1'b1;
      SC_P1_RIGHT:  m[K1_RIGHT]  = 1'b1;
      SC_P1_FIRE1A: m[K1_FIRE1A] = 1'b1;
      SC_P1_FIRE1B: m[K1_FIRE1B] = 1'b1;
      SC_P1_FIRE2:  m[K1_FIRE2]  = 1'b1;
      SC_P1_START:  m[K1_START]  = 1'b1;
      SC_P1_COIN:   m[K1_COIN]   = 1'b1;
      SC_P2_UP:     m[K2_UP]     = 1'b1;
      SC_P2_DOWN:   m[K2_DOWN]   = 1'b1;
      SC_P2_LEFT:   m[K2_LEFT]   = 1'b1;
      SC_P2_RIGHT:  m[K2_RIGHT]  = 1'b1;
      SC_P2_FIRE1:  m[K2_FIRE1]  = 1'b1;
      SC_P2_FIRE2:  m[K2_FIRE2]  = 1'b1;
      SC_P2_START:  m[K2_START]  = 1'b1;
      SC_P2_COIN:   m[K2_COIN]   = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

  // Keyboard contribution to a player byte, already in p_ctl order.
  function automatic logic [7:0] kb_ctl(input logic [NUM_KEYS-1:0] k, input int player);
    logic [7:0] c;
    c = '0;
    if (player == 0) begin
      c[CTL_UP]    = k[K1_UP];
      c[CTL_DOWN]  = k[K1_DOWN];
      c[CTL_LEFT]  = k[K1_LEFT];
      c[CTL_RIGHT] = k[K1_RIGHT];
      c[CTL_FIRE1] = k[K1_FIRE1A] | k[K1_FIRE1B];
      c[CTL_FIRE2] = k[K1_FIRE2];
      c[CTL_START] = k[K1_START];
      c[CTL_COIN]  = k[K1_COIN];
    end else if (player == 1) begin
      c[CTL_UP]    = k[K2_UP];
      c[CTL_DOWN]  = k[K2_DOWN];
      c[CTL_LEFT]  = k[K2_LEFT];
      c[CTL_RIGHT] = k[K2_RIGHT];
      c[CTL_FIRE1] = k[K2_FIRE1];
      c[CTL_FIRE2] = k[K2_FIRE2];
      c[CTL_START] = k[K2_START];
      c[CTL_COIN]  = k[K2_COIN];
    end
    return c;
  endfunction

  // Joystick byte reordered into p_ctl bit order.
  function automatic logic [7:0] joy_to_ctl(input logic [7:0] j);
    logic [7:0] c;
    c            = '0;
    c[CTL_UP]    = j[JOY_UP];
    c[CTL_DOWN]  = j[JOY_DOWN];
    c[CTL_LEFT]  = j[JOY_LEFT];
    c[CTL_RIGHT] = j[JOY_RIGHT];
    c[CTL_FIRE1] = j[JOY_FIRE1];
    c[CTL_FIRE2] = j[JOY_FIRE2];
    c[CTL_START] = j[JOY_START];
    c[CTL_COIN]  = j[JOY_COIN];
    return c;
  endfunction

  // Remap the four direction bits for the selected screen rotation.
  function automatic logic [3:0] rotate_dirs(input logic [3:0] d, input rot_e r);
    logic [3:0] o;
    o = d;
    case (r)
      ROT_90: begin
        o[CTL_UP]    = d[CTL_LEFT];
        o[CTL_DOWN]  = d[CTL_RIGHT];
        o[CTL_LEFT]  = d[CTL_DOWN];
        o[CTL_RIGHT] = d[CTL_UP];
      end
      ROT_180: begin
        o[CTL_UP]    = d[CTL_DOWN];
        o[CTL_DOWN]  = d[CTL_UP];
        o[CTL_LEFT]  = d[CTL_RIGHT];
        o[CTL_RIGHT] = d[CTL_LEFT];
      end
      ROT_270: begin
        o[CTL_UP]    = d[CTL_RIGHT];
        o[CTL_DOWN]  = d[CTL_LEFT];
        o[CTL_LEFT]  = d[CTL_UP];
        o[CTL_RIGHT] = d[CTL_DOWN];
      end
      default: ;
    endcase
    return o;
  endfunction

  // Opposing directions cancel to neutral.
  function automatic logic [3:0] socd_clean(input logic [3:0] d);
    logic [3:0] o;
    o = d;
    if (d[CTL_UP] && d[CTL_DOWN]) begin
      o[CTL_UP]   = 1'b0;
      o[CTL_DOWN] = 1'b0;
    end
    if (d[CTL_LEFT] && d[CTL_RIGHT]) begin
      o[CTL_LEFT]  = 1'b0;
      o[CTL_RIGHT] = 1'b0;
    end
    return o;
  endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// Per-player coin pulse shaper: one fixed-length pulse per coin press,
// measured in coin_ce ticks, re-armed only after the coin input is released.
module arcade_coin_pulse
  import arcade_input_pkg::*;
#(
  parameter int COIN_TICKS = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_coin_raw,
  input  logic i_coin_ce,
  output logic o_pulse
);

  coin_st_e   r_state;
  logic [3:0] r_cnt;
  logic       r_prev;
  logic       r_pulse;

  // Coin FSM with registered pulse output
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= COIN_IDLE;
      r_cnt   <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev <= i_coin_raw;
      case (r_state)
        COIN_IDLE: begin
          if (i_coin_raw && !r_prev) begin
            r_state <= COIN_PULSE;
            r_cnt   <= 4'(COIN_TICKS);
            r_pulse <= 1'b1;
          end
        end
        COIN_PULSE: begin
          if (i_coin_ce) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= COIN_WAIT_REL;
              r_pulse <= 1'b0;
            end
          end
        end
        COIN_WAIT_REL: begin
          if (!i_coin_raw) r_state <= COIN_IDLE;
        end
        default: begin
          r_state <= COIN_IDLE;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/arcade_input_map.sv
// Keyboard + joystick to per-player arcade control bytes: PS/2 key state,
// joystick OR, screen rotation, optional SOCD cleanup and coin pulses.
module arcade_input_map
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int COIN_TICKS  = 4,
  parameter int SOCD_CLEAN  = 1
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [10:0]              ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joystick,
  input  logic [1:0]               rotate,
  input  logic                     coin_ce,
  output logic [8*NUM_PLAYERS-1:0] p_ctl
);

  logic [NUM_KEYS-1:0]             r_keys;
  logic                            r_tog;
  logic [NUM_PLAYERS-1:0][7:0]     r_joy;
  logic                            w_event;
  logic [NUM_KEYS-1:0]             w_match;
  logic                            w_unused;

  assign w_event = ps2_key[10] != r_tog;
  assign w_match = key_match(ps2_key[7:0]);

  // Bits the mapper deliberately ignores: extended prefix, joystick extras
  always_comb begin
    w_unused = ps2_key[8];
    for (int p = 0; p < NUM_PLAYERS; p++)
      w_unused = w_unused ^ (^joystick[16*p+8 +: 8]);
  end

  // Input stage: key state from toggle-detected events, joystick capture.
  // The toggle copy reloads during reset so release never fakes an event.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_keys <= '0;
      r_tog  <= ps2_key[10];
      r_joy  <= '0;
    end else begin
      r_tog <= ps2_key[10];
      if (w_event)
        r_keys <= (r_keys & ~w_match) | (w_match & {NUM_KEYS{ps2_key[9]}});
      for (int p = 0; p < NUM_PLAYERS; p++)
        r_joy[p] <= joystick[16*p +: 8];
    end
  end

  for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
    logic [7:0] w_raw;
    logic [3:0] w_rot;
    logic [3:0] w_dir;
    logic [6:0] r_ctl;
    logic       w_coin;

    assign w_raw = kb_ctl(r_keys, gp) | joy_to_ctl(r_joy[gp]);
    assign w_rot = rotate_dirs(w_raw[3:0], rot_e'(rotate));

    if (SOCD_CLEAN != 0) begin : g_socd
      assign w_dir = socd_clean(w_rot);
    end else begin : g_nosocd
      assign w_dir = w_rot;
    end

    // Output register for directions and buttons
    always_ff @(posedge clk_sys) begin
      if (reset) r_ctl <= '0;
      else       r_ctl <= {w_raw[CTL_START:CTL_FIRE1], w_dir};
    end

    arcade_coin_pulse #(
      .COIN_TICKS(COIN_TICKS)
    ) u_coin (
      .i_clk     (clk_sys),
      .i_reset   (reset),
      .i_coin_raw(w_raw[CTL_COIN]),
      .i_coin_ce (coin_ce),
      .o_pulse   (w_coin)
    );

    assign p_ctl[8*gp +: 8] = {w_coin, r_ctl};
  end

endmodule

// File: tb/tb_arcade_input_map.sv
// Bench for arcade_input_map: two configurations driven by shared stimulus,
// checked every cycle against a behavioural model, plus directed scenarios.
module tb_arcade_input_map;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [63:0] joy;
  logic [1:0]  rotate;
  logic        coin_ce;
  logic [15:0] p2;
  logic [31:0] p4;

  always #5 clk_sys = ~clk_sys;

  arcade_input_map #(.NUM_PLAYERS(2), .COIN_TICKS(4), .SOCD_CLEAN(1)) dut2 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick(joy[31:0]),
    .rotate(rotate), .coin_ce(coin_ce), .p_ctl(p2));

  arcade_input_map #(.NUM_PLAYERS(4), .COIN_TICKS(3), .SOCD_CLEAN(0)) dut4 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick(joy),
    .rotate(rotate), .coin_ce(coin_ce), .p_ctl(p4));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;

  // ---------------- behavioural model ----------------
  bit         held[256];
  logic [63:0] joyq = '0;
  bit         togq = 0;
  int         np[2]    = '{2, 4};
  int         ticks[2] = '{4, 3};
  bit         socd[2]  = '{1, 0};
  logic [7:0] exp_ctl[2][4];
  int         cleft[2][4];
  bit         clatch[2][4];
  bit         cprev[2][4];

  initial begin
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 4; p++) begin
        exp_ctl[c][p] = '0; cleft[c][p] = 0; clatch[c][p] = 0; cprev[c][p] = 0;
      end
    for (int i = 0; i < 256; i++) held[i] = 0;
  end

  // Control byte a player requests before rotation (up,down,left,right,f1,f2,start,coin)
  function automatic logic [7:0] raw_of(int p);
    logic [7:0]  r;
    logic [15:0] j;
    r = '0;
    if (p == 0) begin
      r[0] = held[8'h75]; r[1] = held[8'h72]; r[2] = held[8'h6B]; r[3] = held[8'h74];
      r[4] = held[8'h14] | held[8'h29]; r[5] = held[8'h11]; r[6] = held[8'h16]; r[7] = held[8'h2E];
    end else if (p == 1) begin
      r[0] = held[8'h2D]; r[1] = held[8'h2B]; r[2] = held[8'h23]; r[3] = held[8'h34];
      r[4] = held[8'h1C]; r[5] = held[8'h1B]; r[6] = held[8'h1E]; r[7] = held[8'h36];
    end
    j = joyq[16*p +: 16];
    r[0] |= j[3]; r[1] |= j[2]; r[2] |= j[1]; r[3] |= j[0];
    r[7:4] |= j[7:4];
    return r;
  endfunction

  // Directions as unit vectors turned clockwise by 90 degrees per rotate step
  function automatic logic [3:0] rot_model(logic [3:0] d, int mode);
    int vx[4];
    int vy[4];
    int x, y, t;
    logic [3:0] o;
    vx = '{0, 0, -1, 1};
    vy = '{1, -1, 0, 0};
    o = '0;
    for (int k = 0; k < 4; k++) begin
      if (d[k]) begin
        x = vx[k]; y = vy[k];
        for (int s = 0; s < mode; s++) begin t = x; x = y; y = -t; end
        for (int m = 0; m < 4; m++)
          if (vx[m] == x && vy[m] == y) o[m] = 1'b1;
      end
    end
    return o;
  endfunction

  // Advance the model across one rising edge using the inputs sampled there
  task automatic model_step();
    logic [7:0] raw[4];
    logic [3:0] d;
    bit rc;
    for (int p = 0; p < 4; p++) raw[p] = raw_of(p);
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < np[c]; p++) begin
        if (reset) begin
          exp_ctl[c][p] = '0; cleft[c][p] = 0; clatch[c][p] = 0; cprev[c][p] = 0;
        end else begin
          d = rot_model(raw[p][3:0], int'(rotate));
          if (socd[c]) begin
            if (d[0] && d[1]) d[1:0] = 2'b00;
            if (d[2] && d[3]) d[3:2] = 2'b00;
          end
          rc = raw[p][7];
          if (cleft[c][p] > 0) begin
            if (coin_ce) cleft[c][p]--;
          end else if (clatch[c][p]) begin
            if (!rc) clatch[c][p] = 0;
          end else if (rc && !cprev[c][p]) begin
            cleft[c][p] = ticks[c];
            clatch[c][p] = 1;
          end
          cprev[c][p] = rc;
          exp_ctl[c][p] = {(cleft[c][p] > 0), raw[p][6:4], d};
        end
      end
    end
    if (reset) begin
      for (int i = 0; i < 256; i++) held[i] = 0;
      joyq = '0;
      togq = ps2_key[10];
    end else begin
      if (ps2_key[10] != togq) held[ps2_key[7:0]] = ps2_key[9];
      togq = ps2_key[10];
      joyq = joy;
    end
  endtask

  // ---------------- checking ----------------
  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model
  always @(negedge clk_sys) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (p2[8*p +: 8] !== exp_ctl[0][p]) begin
          failures++;
          $display("FAIL model2 player=%0d cyc=%0d got=%h want=%h", p, cyc, p2[8*p +: 8], exp_ctl[0][p]);
        end
      end
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (p4[8*p +: 8] !== exp_ctl[1][p]) begin
          failures++;
          $display("FAIL model4 player=%0d cyc=%0d got=%h want=%h", p, cyc, p4[8*p +: 8], exp_ctl[1][p]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    cyc++;
    @(negedge clk_sys);
    #1;
  endtask

  task automatic key(input bit pressed, input logic [7:0] sc, input bit ext);
    ps2_key = {~ps2_key[10], pressed, ext, sc};
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] codes[18];
  int hi2, hi4, rise2, rise4;
  bit pv2, pv4;

  initial begin
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29, 8'h11, 8'h16, 8'h2E,
              8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h1E, 8'h36, 8'h55};
    reset = 1'b1; ps2_key = 11'h400; joy = '0; rotate = 2'd0; coin_ce = 1'b0;
    tick(); chk_en = 1; tick();
    lit("reset p2", {16'h0, p2}, 32'h0);
    lit("reset p4", p4, 32'h0);
    reset = 1'b0;
    tick();
    lit("no spurious event", {16'h0, p2}, 32'h0);

    // key 75 extended: two-edge latency, release clears
    key(1, 8'h75, 1);
    tick(); lit("up after 1 edge", p2[0], 0);
    tick(); lit("up after 2 edges", p2[0], 1);
    lit("model up", exp_ctl[0][0], 32'h01);
    key(0, 8'h75, 1);
    tick(); tick(); lit("up released", p2[0], 0);

    // rotation of joystick up
    joy[15:0] = 16'h0008; rotate = 2'd1;
    tick(); tick(); lit("rot90 up->right", p2[7:0], 32'h08);
    lit("model rot90", exp_ctl[0][0], 32'h08);
    rotate = 2'd3; tick(); lit("rot270 up->left", p2[7:0], 32'h04);
    rotate = 2'd2; tick(); lit("rot180 up->down", p2[7:0], 32'h02);
    rotate = 2'd0; joy = '0; tick(); tick();

    // SOCD: key up plus joystick down
    key(1, 8'h75, 0); joy[15:0] = 16'h0004;
    tick(); tick();
    lit("socd clean", p2[1:0], 32'h0);
    lit("socd off", p4[1:0], 32'h3);
    key(0, 8'h75, 0); joy = '0; tick(); tick();

    // coin held across 10 coin_ce ticks: a single fixed-length pulse
    key(1, 8'h2E, 0);
    hi2 = 0; hi4 = 0; rise2 = 0; rise4 = 0; pv2 = 0; pv4 = 0;
    for (int i = 0; i < 40; i++) begin
      coin_ce = (i % 4 == 3);
      if (p2[7] && coin_ce) hi2++;
      if (p4[7] && coin_ce) hi4++;
      if (p2[7] && !pv2) rise2++;
      if (p4[7] && !pv4) rise4++;
      pv2 = p2[7]; pv4 = p4[7];
      tick();
    end
    coin_ce = 0;
    lit("coin ticks 4", hi2, 4);
    lit("coin ticks 3", hi4, 3);
    lit("coin one pulse", rise2, 1);
    lit("coin one pulse 4", rise4, 1);

    // release and re-press gives a second pulse
    key(0, 8'h2E, 0); tick(); tick(); tick();
    key(1, 8'h2E, 0);
    rise2 = 0; pv2 = 0;
    for (int i = 0; i < 24; i++) begin
      coin_ce = (i % 4 == 3);
      if (p2[7] && !pv2) rise2++;
      pv2 = p2[7];
      tick();
    end
    coin_ce = 0;
    lit("coin re-press", rise2, 1);

    // reset mid-pulse
    key(0, 8'h2E, 0); tick(); tick(); tick();
    key(1, 8'h2E, 0); tick(); tick();
    lit("coin pulse on", p2[7], 1);
    reset = 1'b1; tick();
    lit("reset drops coin", p2[7], 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin coin_ce = (i % 2 == 1); tick(); end
    coin_ce = 0;
    lit("held key no retrigger", p2[7], 0);
    key(0, 8'h2E, 0); tick(); tick();

    // player 4 fire2 from joystick 3
    joy[63:48] = 16'h0020; tick(); tick();
    lit("p4 fire2 bit29", p4[29], 1);
    joy = '0; tick(); tick();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 3 == 0)
        key(1'($urandom % 2), codes[$urandom % 18], 1'($urandom % 2));
      if ($urandom % 6 == 0) begin
        int p, b;
        p = $urandom % 4; b = $urandom % 8;
        joy[16*p + b] = ~joy[16*p + b];
      end
      if ($urandom % 40 == 0) joy[15:8] = 8'($urandom);
      if ($urandom % 50 == 0) rotate = 2'($urandom);
      coin_ce = ($urandom % 4 == 0);
      reset = ($urandom % 300 == 0);
      tick();
    end
    reset = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
